// File: rtl/uart_baud_gen.sv
// UART baud-rate generator.
// A period counter produces one oversample tick every INT (or INT+1) clocks.
// A phase counter divides those ticks into bit ticks and mid-bit sample ticks.
// A new divisor can be loaded at run time. It waits as pending until the next
// period wrap, or it takes effect at once while stopped or on a sync restart.
// Build option: define UART_BAUD_FRAC_EN to add the fractional accumulator.
// The accumulator stretches some periods by one clock so that the average
// period is INT + FRAC/2^FRAC_W clocks.
`timescale 1ns/1ps

module uart_baud_gen #(
  parameter int FREQ     = 100_000_000,
  parameter int BAUDRATE = 2400,
  parameter int RATIO    = 8,
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic              div_load_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              os_ce_o,
  output logic              bit_ce_o,
  output logic              mid_ce_o,
  output logic              load_pending_o,
  output logic              err_o
);

  localparam int     PH_W     = $clog2(RATIO);
  localparam longint DEN      = longint'(BAUDRATE) * longint'(RATIO);
  localparam longint INT_CALC = longint'(FREQ) / DEN;
  localparam logic [DIV_W-1:0] INT_RST = INT_CALC[DIV_W-1:0];

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(RATIO / 2 - 1);

  logic [DIV_W-1:0] r_int;
  logic [DIV_W-1:0] r_pend_int;
  logic             r_pending;
  logic             r_err;
  logic [DIV_W-1:0] r_cnt;
  logic [PH_W-1:0]  r_ph;
  logic             r_os;
  logic             r_bit;
  logic             r_mid;

  logic w_load_ok;
  logic w_load_bad;
  logic w_restart;
  logic w_last;
  logic w_wrap;

  // A divisor below 2 cannot produce a period, so such a load is refused.
  assign w_load_ok  = div_load_i && (div_int_i >= DIV_W'(2));
  assign w_load_bad = div_load_i && (div_int_i <  DIV_W'(2));
  assign w_restart  = !en_i || sync_i;
  assign w_wrap     = en_i && !sync_i && w_last;

`ifdef UART_BAUD_FRAC_EN
  localparam longint FRAC_CALC = (longint'(FREQ) << FRAC_W) / DEN;
  localparam logic [FRAC_W-1:0] FRAC_RST = FRAC_CALC[FRAC_W-1:0];

  logic [FRAC_W-1:0] r_frac;
  logic [FRAC_W-1:0] r_pend_frac;
  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;
  logic [FRAC_W-1:0] w_frac_eff;
  logic [FRAC_W:0]   w_acc_sum;

  // The wrap that applies a pending divisor already accumulates the new fraction.
  assign w_frac_eff = r_pending ? r_pend_frac : r_frac;
  assign w_acc_sum  = {1'b0, r_acc} + {1'b0, w_frac_eff};
  // A carry from the previous wrap stretches this period by one clock.
  assign w_last     = r_carry ? (r_cnt == r_int) : (r_cnt == r_int - DIV_W'(1));

  // Fractional divisor: active and pending copies follow the integer part.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_frac      <= FRAC_RST;
      r_pend_frac <= '0;
    end else if (w_restart) begin
      if (w_load_ok)      r_frac <= div_frac_i;
      else if (r_pending) r_frac <= r_pend_frac;
    end else begin
      if (w_wrap && r_pending) r_frac      <= r_pend_frac;
      if (w_load_ok)           r_pend_frac <= div_frac_i;
    end
  end

  // Accumulator advances once per period; it is cleared by a stop or a sync restart.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (w_restart) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (w_last) begin
      r_acc   <= w_acc_sum[FRAC_W-1:0];
      r_carry <= w_acc_sum[FRAC_W];
    end
  end
`else
  logic w_unused_frac;

  assign w_unused_frac = ^div_frac_i;
  assign w_last        = (r_cnt == r_int - DIV_W'(1));
`endif

  // Integer divisor and load handling.
  // While stopped or on a sync restart, a load is written straight into the
  // active divisor, so the restarted period already uses the new value.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_int      <= INT_RST;
      r_pend_int <= '0;
      r_pending  <= 1'b0;
    end else if (w_restart) begin
      r_pending <= 1'b0;
      if (w_load_ok)      r_int <= div_int_i;
      else if (r_pending) r_int <= r_pend_int;
    end else begin
      if (w_wrap && r_pending) begin
        r_int     <= r_pend_int;
        r_pending <= 1'b0;
      end
      if (w_load_ok) begin
        r_pend_int <= div_int_i;
        r_pending  <= 1'b1;
      end
    end
  end

  // Sticky error flag for refused loads.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)         r_err <= 1'b0;
    else if (w_load_bad) r_err <= 1'b1;
  end

  // Period counter, phase counter and registered tick outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
      r_ph  <= '0;
      r_os  <= 1'b0;
      r_bit <= 1'b0;
      r_mid <= 1'b0;
    end else if (w_restart) begin
      r_cnt <= '0;
      r_ph  <= '0;
      r_os  <= 1'b0;
      r_bit <= 1'b0;
      r_mid <= 1'b0;
    end else if (w_last) begin
      r_cnt <= '0;
      r_os  <= 1'b1;
      r_bit <= (r_ph == PH_LAST);
      r_mid <= (r_ph == PH_MID);
      r_ph  <= (r_ph == PH_LAST) ? '0 : r_ph + PH_W'(1);
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
      r_os  <= 1'b0;
      r_bit <= 1'b0;
      r_mid <= 1'b0;
    end
  end

  assign os_ce_o        = r_os;
  assign bit_ce_o       = r_bit;
  assign mid_ce_o       = r_mid;
  assign load_pending_o = r_pending;
  assign err_o          = r_err;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen. The DUT is built with a small clock frequency, so
// that INT = 50 and FRAC = 5 and runs stay short.
// Expected tick intervals are queued when stimulus is applied. A monitor pops
// one entry on each os tick and compares it with the measured interval.
`timescale 1ns/1ps

module tb_uart_baud_gen;

  localparam int FREQ     = 966_000;
  localparam int BAUDRATE = 2400;
  localparam int RATIO    = 8;
  localparam int DIV_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int INT0     = 50;
  localparam int F0       = 5;
`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC_ON  = 1'b1;
`else
  localparam bit FRAC_ON  = 1'b0;
`endif

  logic              clk;
  logic              rstn;
  logic              en;
  logic              sync;
  logic              load;
  logic [DIV_W-1:0]  d_int;
  logic [FRAC_W-1:0] d_frac;
  logic              os_ce, bit_ce, mid_ce, pend, err;

  uart_baud_gen #(
    .FREQ(FREQ), .BAUDRATE(BAUDRATE), .RATIO(RATIO), .DIV_W(DIV_W), .FRAC_W(FRAC_W)
  ) u_dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .sync_i(sync),
    .div_load_i(load), .div_int_i(d_int), .div_frac_i(d_frac),
    .os_ce_o(os_ce), .bit_ce_o(bit_ce), .mid_ce_o(mid_ce),
    .load_pending_o(pend), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ivl;
    bit bit_e;
    bit mid_e;
    bit ph_chk;
    bit in_span;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   last_ref = 0;
  int   span_acc = 0;
  int   n_chk    = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
  endtask

  // Number of accumulator carries after j periods with fraction f.
  function automatic int carries(input int j, input int f);
    return (j * f) / (1 << FRAC_W);
  endfunction

  // Interval of the k-th tick (1-based) after a restart that clears the accumulator.
  function automatic int exp_ivl(input int k, input int intv, input int f);
    if (k < 2) return intv;
    return intv + carries(k - 1, f) - carries(k - 2, f);
  endfunction

  task automatic push_run(input int n, input int intv, input int f,
                          input bit ph_chk, input bit span_from2);
    exp_t e;
    int   fe;
    fe = FRAC_ON ? f : 0;
    for (int k = 1; k <= n; k++) begin
      e.ivl     = exp_ivl(k, intv, fe);
      e.bit_e   = (k % RATIO) == 0;
      e.mid_e   = (k % RATIO) == RATIO / 2;
      e.ph_chk  = ph_chk;
      e.in_span = span_from2 && (k >= 2);
      sb.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (sb.size() > 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor: samples 1 ns after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (!rstn || !en || sync) begin
        last_ref = cyc;
      end else if (os_ce) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("os_ivl", cyc - last_ref, e.ivl);
          if (e.in_span) span_acc += cyc - last_ref;
          if (e.ph_chk) begin
            check("bit_ce", int'(bit_ce), int'(e.bit_e));
            check("mid_ce", int'(mid_ce), int'(e.mid_e));
          end
        end
        last_ref = cyc;
      end
      if (!os_ce && (bit_ce || mid_ce)) check("stray_ce", int'({bit_ce, mid_ce}), 0);
    end
  end

  initial begin
    int i;
    rstn = 1'b0; en = 1'b0; sync = 1'b0; load = 1'b0; d_int = '0; d_frac = '0;
    step(3);
    check("rst_os",   int'(os_ce),  0);
    check("rst_bit",  int'(bit_ce), 0);
    check("rst_mid",  int'(mid_ce), 0);
    check("rst_pend", int'(pend),   0);
    check("rst_err",  int'(err),    0);

    // Reset divisor: 16 steady-state periods span 16*INT + FRAC clocks.
    en = 1'b1;
    span_acc = 0;
    push_run(17, INT0, F0, 1'b1, 1'b1);
    rstn = 1'b1;
    drain(2000);
    check("span16", span_acc, 16 * INT0 + (FRAC_ON ? F0 : 0));

    // Mid-period load, overwritten while pending; applied at the wrap.
    step(20);
    load = 1'b1; d_int = 16'd7; d_frac = 4'd0;
    step(1);
    d_int = 16'd4;
    step(1);
    load = 1'b0;
    check("pend_set", int'(pend), 1);
    check("err_clear", int'(err), 0);
    i = 0;
    while (pend && i < 200) begin
      step(1);
      i++;
    end
    check("pend_clear_at_tick", int'({pend, os_ce}), 1);
    push_run(6, 4, 0, 1'b0, 1'b0);
    drain(200);

    // Sync restart with INT=4: mid tick 16 clocks later, bit tick 32 clocks later.
    push_run(8, 4, 0, 1'b1, 1'b0);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    drain(200);

    // Sync and load in the same cycle: the restarted period uses 4 + 8/16.
    push_run(10, 4, 8, 1'b1, 1'b0);
    sync = 1'b1; load = 1'b1; d_int = 16'd4; d_frac = 4'd8;
    step(1);
    sync = 1'b0; load = 1'b0;
    drain(200);

    // Refused load (INT=1): sticky error, timing and pending state unaffected.
    push_run(10, 4, 8, 1'b1, 1'b0);
    sync = 1'b1;
    step(1);
    sync = 1'b0; load = 1'b1; d_int = 16'd1; d_frac = 4'd3;
    step(1);
    load = 1'b0;
    check("err_set", int'(err), 1);
    check("pend_rejected", int'(pend), 0);
    drain(200);
    check("err_hold", int'(err), 1);

    // Load while disabled; the first tick comes INT clocks after enable.
    en = 1'b0;
    step(1);
    load = 1'b1; d_int = 16'd6; d_frac = 4'd0;
    step(1);
    load = 1'b0;
    step(3);
    check("en_low_ce", int'({os_ce, bit_ce, mid_ce}), 0);
    push_run(8, 6, 0, 1'b1, 1'b0);
    en = 1'b1;
    drain(200);

    // Asynchronous reset while a tick is high.
    i = 0;
    while (!os_ce && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("rst_hit_tick", int'(os_ce), 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_os",   int'(os_ce),  0);
    check("arst_bit",  int'(bit_ce), 0);
    check("arst_mid",  int'(mid_ce), 0);
    check("arst_pend", int'(pend),   0);
    check("arst_err",  int'(err),    0);
    @(negedge clk);
    step(2);
    push_run(9, INT0, F0, 1'b1, 1'b0);
    rstn = 1'b1;
    drain(1000);
    check("err_after_rst", int'(err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
